// File: rtl/larpix_readout_pkg.sv
// Shared constants and types for the ADC readout arbiter and anything
// downstream that consumes its events.
package larpix_readout_pkg;

    localparam int NUMCHANNELS = 64;
    localparam int ADCBITS     = 10;
    localparam int TS_BITS     = 32;
    localparam int CH_W        = $clog2(NUMCHANNELS);

    typedef enum logic {
        IDLE,
        LOADED
    } readout_state_t;

    typedef struct packed {
        logic [CH_W-1:0]    channel;
        logic [ADCBITS-1:0] adc;
        logic [TS_BITS-1:0] timestamp;
    } readout_event_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker: lowest requesting index at or above rr_ptr,
// otherwise the lowest requesting index overall.
module rr_priority_picker #(
    parameter  int NUMCHANNELS = 64,
    localparam int CH_W        = $clog2(NUMCHANNELS)
) (
    input  logic [NUMCHANNELS-1:0] req,
    input  logic [CH_W-1:0]        rr_ptr,
    output logic [CH_W-1:0]        winner,
    output logic                   any_req
);

    logic [CH_W-1:0] hi_idx;
    logic [CH_W-1:0] lo_idx;
    logic            hi_found;
    logic            lo_found;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        hi_idx   = '0;
        lo_idx   = '0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        // Scanning downwards lets the last hit be the lowest index.
        for (int i = NUMCHANNELS - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx   = CH_W'(i);
                lo_found = 1'b1;
                if (i >= int'(rr_ptr)) begin
                    hi_idx   = CH_W'(i);
                    hi_found = 1'b1;
                end
            end
        end
        any_req = lo_found;
        winner  = hi_found ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/adc_readout_arbiter.sv
// Round-robin arbiter sharing one event path among the per-channel ADCs;
// captures the granted channel's word and timestamp behind a valid/ready pair.
module adc_readout_arbiter
    import larpix_readout_pkg::readout_state_t;
    import larpix_readout_pkg::IDLE;
    import larpix_readout_pkg::LOADED;
#(
    parameter  int NUMCHANNELS = larpix_readout_pkg::NUMCHANNELS,
    parameter  int ADCBITS     = larpix_readout_pkg::ADCBITS,
    parameter  int TS_BITS     = larpix_readout_pkg::TS_BITS,
    localparam int CH_W        = $clog2(NUMCHANNELS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUMCHANNELS-1:0]         done,
    input  logic [ADCBITS*NUMCHANNELS-1:0] dout,
    input  logic [NUMCHANNELS-1:0]         channel_mask,
    input  logic [TS_BITS-1:0]             timestamp,
    input  logic                           event_ready,
    output logic                           event_valid,
    output logic [CH_W-1:0]                event_channel,
    output logic [ADCBITS-1:0]             event_adc,
    output logic [TS_BITS-1:0]             event_timestamp,
    output logic [NUMCHANNELS-1:0]         ack,
    output logic [15:0]                    event_count
);

    readout_state_t          state;
    logic [NUMCHANNELS-1:0]  in_service;
    logic [CH_W-1:0]         rr_ptr;
    logic [NUMCHANNELS-1:0]  req;
    logic [CH_W-1:0]         winner;
    logic                    any_req;
    logic                    grant;
    logic                    deliver;
    logic [NUMCHANNELS-1:0]  grant_onehot;
    logic [CH_W-1:0]         next_ptr;
    logic [ADCBITS-1:0]      adc_word [NUMCHANNELS];

    // A channel already granted stays out of arbitration until its done drops.
    assign req = done & ~channel_mask & ~in_service;

    rr_priority_picker #(
        .NUMCHANNELS (NUMCHANNELS)
    ) u_picker (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    assign deliver      = event_valid && event_ready;
    assign grant        = any_req && ((state == IDLE) || deliver);
    assign grant_onehot = {{(NUMCHANNELS-1){1'b0}}, 1'b1} << winner;
    assign next_ptr     = (winner == CH_W'(NUMCHANNELS - 1)) ? '0 : winner + 1'b1;

    always_comb begin
        for (int i = 0; i < NUMCHANNELS; i++) begin
            adc_word[i] = dout[ADCBITS*i +: ADCBITS];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            state           <= IDLE;
            event_valid     <= 1'b0;
            event_channel   <= '0;
            event_adc       <= '0;
            event_timestamp <= '0;
            ack             <= '0;
            event_count     <= '0;
            rr_ptr          <= '0;
            in_service      <= '0;
        end else begin
            in_service <= (in_service & done) | (grant ? grant_onehot : '0);
            ack        <= grant ? grant_onehot : '0;

            if (deliver && (event_count != 16'hFFFF)) begin
                event_count <= event_count + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (grant) begin
                        state           <= LOADED;
                        event_valid     <= 1'b1;
                        event_channel   <= winner;
                        event_adc       <= adc_word[winner];
                        event_timestamp <= timestamp;
                        rr_ptr          <= next_ptr;
                    end
                end
                LOADED: begin
                    // Without event_ready the held event and pointer are frozen.
                    if (grant) begin
                        event_valid     <= 1'b1;
                        event_channel   <= winner;
                        event_adc       <= adc_word[winner];
                        event_timestamp <= timestamp;
                        rr_ptr          <= next_ptr;
                    end else if (event_ready) begin
                        state       <= IDLE;
                        event_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/adc_readout_arbiter.md
Name: adc_readout_arbiter

Overview:
- Shares the single downstream event path between the 64 per-channel ADCs of the analog core.
- Watches the per-channel `done` flags and grants one channel at a time, round-robin.
- On grant, captures that channel's ADC word and the current timestamp into an output register, offered with a valid/ready handshake.
- Sits between the analog_core `dout`/`done` outputs and the digital_core event FIFO. It returns a one-cycle `ack` per channel so the channel sequencer can re-arm.

Parameters:
- NUMCHANNELS, 64, number of analog channels.
- ADCBITS, 10, bits per ADC conversion.
- TS_BITS, 32, timestamp width.
- CH_W, $clog2(NUMCHANNELS), channel index width (derived, not overridable).

Ports:
- clk  input  1  master clock.
- reset  input  1  synchronous, active-high reset.
- done  input  NUMCHANNELS  per-channel conversion-complete level, held high until channel re-arms.
- dout  input  ADCBITS*NUMCHANNELS  packed ADC words; channel i at bits [ADCBITS*i +: ADCBITS].
- channel_mask  input  NUMCHANNELS  1 = channel excluded from arbitration.
- timestamp  input  TS_BITS  free-running time counter.
- event_ready  input  1  downstream accepts event this cycle.
- event_valid  output  1  output register holds an undelivered event.
- event_channel  output  CH_W  channel index of held event.
- event_adc  output  ADCBITS  ADC word of held event.
- event_timestamp  output  TS_BITS  timestamp sampled at grant.
- ack  output  NUMCHANNELS  one-hot, one-cycle pulse on the granting cycle.
- event_count  output  16  saturating count of delivered events.

Behaviour:
- Reset (synchronous, active-high):
  - Values: event_valid=0, event_channel=0, event_adc=0, event_timestamp=0, ack=0, event_count=0, rr_ptr=0, in_service=0, state=IDLE.
  - Reset asserted mid-handshake discards the held event; no ack is reissued.
- Request vector: req = done & ~channel_mask & ~in_service.
- in_service[i]:
  - Set on the cycle channel i is granted.
  - Cleared on any cycle where done[i]==0.
  - Prevents a still-high `done` from being granted twice.
- Pick:
  - Winner w is the lowest index >= rr_ptr with req set; if none, the lowest index with req set.
  - Purely combinational from req and rr_ptr.
- Grant condition: |req && (state==IDLE || (event_valid && event_ready)).
- On grant (registered, visible next cycle):
  - event_valid=1, event_channel=w, event_adc=dout slice w, event_timestamp=timestamp (sampled in the grant cycle).
  - ack = one-hot w for exactly one cycle.
  - rr_ptr = w+1, wrapping NUMCHANNELS-1 -> 0.
  - state=LOADED.
- States:
  - IDLE -> LOADED on grant.
  - LOADED + event_ready + grant -> LOADED with the new event (back-to-back, one event per cycle throughput).
  - LOADED + event_ready + no req -> IDLE, event_valid=0.
  - LOADED + !event_ready -> hold; all event_* outputs stable, no grant, ack=0.
- Latency: done rising at cycle N (state IDLE, unmasked) -> event_valid and ack high at cycle N+1.
- event_count increments on each event_valid && event_ready and saturates at 16'hFFFF.
- Masking:
  - channel_mask affects only future grants; a held event is still delivered.
  - Masking a channel while its done is high leaves done pending; unmasking later grants it.
- No data loss: while the downstream stalls, pending channels simply wait; no drop path exists.
- Simultaneous done fall and grant for the same channel cannot occur, because a grant requires done=1.

Decomposition:
- Package larpix_readout_pkg holds:
  - NUMCHANNELS, ADCBITS, TS_BITS, CH_W constants;
  - typedef enum logic {IDLE, LOADED} readout_state_t;
  - typedef struct packed {channel, adc, timestamp} readout_event_t.
- One sub-module, rr_priority_picker: combinational, inputs req and rr_ptr, outputs winner index and any_req. Unit-tested separately.

Test Plan:
- Reset: assert reset 3 cycles with done=all-ones -> every output 0, ack=0. After release, first grant is channel 0 one cycle later.
- Single hit: done[5] rises at cycle 10 with dout slice 5=10'h2A5, timestamp=1000, event_ready=1 -> cycle 11 shows event_valid=1, event_channel=5, event_adc=10'h2A5, event_timestamp=1000, ack=64'h20. No second grant while done[5] stays high; event_count=1.
- Full burst: all 64 done high at once, ready=1 -> channels 0,1,...,63 granted on 64 consecutive cycles, then event_valid=0, event_count=64.
- Round-robin fairness: rr_ptr=10 (after granting 9), requests on 3 and 40 -> 40 granted first, then 3.
- Backpressure: event held with event_ready=0 for 20 cycles while done[7] high -> outputs stable, ack stays 0. On ready=1, channel 7 loads the next cycle.
- Mask: channel_mask[12]=1 with done[12]=1 -> no grant for 50 cycles; clearing the mask bit -> ack[12] pulses on the next cycle.
